// File: rtl/axi_id_tag_tracker.sv
// rtl/axi_id_tag_tracker.sv - per-AXI-ID tag FIFOs pairing request tags with final response beats
// Optional same-cycle request-to-response flow-through is enabled by defining AXI_ID_TRACKER_FLOW_EN.
module axi_id_tag_tracker #(
  parameter int ID_W  = 2,
  parameter int DEPTH = 2,
  parameter int TAG_W = 7
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_in_valid,
  output logic                 req_in_ready,
  input  logic [ID_W-1:0]      req_id,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 req_out_valid,
  input  logic                 req_out_ready,
  input  logic                 rsp_in_valid,
  output logic                 rsp_in_ready,
  input  logic [ID_W-1:0]      rsp_id,
  input  logic                 rsp_last,
  output logic                 rsp_out_valid,
  input  logic                 rsp_out_ready,
  output logic [TAG_W-1:0]     rsp_out_tag,
  output logic [2**ID_W-1:0]   busy,
  output logic                 idle
);

  localparam int NUM_IDS = 2**ID_W;
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW      = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] mem    [NUM_IDS][DEPTH];
  logic [PW-1:0]    wr_ptr [NUM_IDS];
  logic [PW-1:0]    rd_ptr [NUM_IDS];
  logic [CW-1:0]    count  [NUM_IDS];

  logic req_full;
  logic rsp_empty;
  logic push;
  logic pop;
  logic flow;
  logic push_store;
  logic pop_store;
  logic rsp_avail;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Gating uses registered occupancy only, so a pop never frees a slot for a same-cycle push.
  always_comb begin
    req_full      = (count[req_id] == CW'(DEPTH));
    rsp_empty     = (count[rsp_id] == '0);
    req_out_valid = req_in_valid & ~req_full;
    req_in_ready  = req_out_ready & ~req_full;
    push          = req_in_valid & req_in_ready;
  end

`ifdef AXI_ID_TRACKER_FLOW_EN
  assign flow = rsp_empty & push & (req_id == rsp_id);
`else
  assign flow = 1'b0;
`endif

  always_comb begin
    rsp_avail     = ~rsp_empty | flow;
    rsp_out_valid = rsp_in_valid & rsp_avail;
    rsp_in_ready  = rsp_out_ready & rsp_avail;
    rsp_out_tag   = flow ? req_tag : mem[rsp_id][rd_ptr[rsp_id]];
    pop           = rsp_in_valid & rsp_in_ready & rsp_last;
    // A flow-through final beat consumes the tag in flight; nothing is stored or popped.
    push_store    = push & ~(flow & pop);
    pop_store     = pop & ~flow;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_IDS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IDS; i++) begin
        if (push_store && (req_id == ID_W'(i))) begin
          wr_ptr[i] <= next_ptr(wr_ptr[i]);
        end
        if (pop_store && (rsp_id == ID_W'(i))) begin
          rd_ptr[i] <= next_ptr(rd_ptr[i]);
        end
        case ({push_store && (req_id == ID_W'(i)), pop_store && (rsp_id == ID_W'(i))})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_store) begin
      mem[req_id][wr_ptr[req_id]] <= req_tag;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_IDS; i++) begin
      busy[i] = (count[i] != '0);
    end
    idle = ~|busy;
  end

endmodule

// File: tb/tb_axi_id_tag_tracker.sv
// tb/tb_axi_id_tag_tracker.sv - scoreboard bench for axi_id_tag_tracker (directed plan plus random traffic)
// Follows AXI_ID_TRACKER_FLOW_EN the same way the design does.
module tb_axi_id_tag_tracker;

  localparam int ID_W    = 2;
  localparam int DEPTH   = 2;
  localparam int TAG_W   = 7;
  localparam int NUM_IDS = 2**ID_W;

  logic               clock;
  logic               reset_n;
  logic               req_in_valid;
  logic               req_in_ready;
  logic [ID_W-1:0]    req_id;
  logic [TAG_W-1:0]   req_tag;
  logic               req_out_valid;
  logic               req_out_ready;
  logic               rsp_in_valid;
  logic               rsp_in_ready;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_last;
  logic               rsp_out_valid;
  logic               rsp_out_ready;
  logic [TAG_W-1:0]   rsp_out_tag;
  logic [NUM_IDS-1:0] busy;
  logic               idle;

  int checks;
  int errors;

  // Expected outstanding tags per ID, oldest first.
  logic [TAG_W-1:0] q [NUM_IDS][$];

  axi_id_tag_tracker #(.ID_W(ID_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_in_valid(req_in_valid), .req_in_ready(req_in_ready),
    .req_id(req_id), .req_tag(req_tag),
    .req_out_valid(req_out_valid), .req_out_ready(req_out_ready),
    .rsp_in_valid(rsp_in_valid), .rsp_in_ready(rsp_in_ready),
    .rsp_id(rsp_id), .rsp_last(rsp_last),
    .rsp_out_valid(rsp_out_valid), .rsp_out_ready(rsp_out_ready),
    .rsp_out_tag(rsp_out_tag), .busy(busy), .idle(idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every output against the queue model, then retires the cycle's handshakes.
  always @(negedge clock) begin
    int  rid, sid;
    bit  full, empty, acc, flw, avail, pop;
    logic [NUM_IDS-1:0] exp_busy;
    rid   = int'(req_id);
    sid   = int'(rsp_id);
    full  = (q[rid].size() == DEPTH);
    empty = (q[sid].size() == 0);
    acc   = req_in_valid && req_out_ready && !full;
`ifdef AXI_ID_TRACKER_FLOW_EN
    flw   = empty && acc && (rid == sid);
`else
    flw   = 1'b0;
`endif
    avail = !empty || flw;
    for (int i = 0; i < NUM_IDS; i++) exp_busy[i] = (q[i].size() != 0);
    check("mon_req_out_valid", 32'(req_out_valid), 32'(req_in_valid && !full));
    check("mon_req_in_ready",  32'(req_in_ready),  32'(req_out_ready && !full));
    check("mon_rsp_out_valid", 32'(rsp_out_valid), 32'(rsp_in_valid && avail));
    check("mon_rsp_in_ready",  32'(rsp_in_ready),  32'(rsp_out_ready && avail));
    check("mon_busy",          32'(busy),          32'(exp_busy));
    check("mon_idle",          32'(idle),          32'(exp_busy == '0));
    if (rsp_in_valid && avail) begin
      check("mon_rsp_tag", 32'(rsp_out_tag), flw ? 32'(req_tag) : 32'(q[sid][0]));
    end
    if (reset_n) begin
      pop = rsp_in_valid && rsp_out_ready && avail && rsp_last;
      if (!(flw && pop)) begin
        if (pop) void'(q[sid].pop_front());
        if (acc) q[rid].push_back(req_tag);
      end
    end
  end

  task automatic set_in(input bit rv, input int rid, input int rtag, input bit ordy,
                        input bit sv, input int sid, input bit sl, input bit srdy);
    req_in_valid  = rv;
    req_id        = ID_W'(rid);
    req_tag       = TAG_W'(rtag);
    req_out_ready = ordy;
    rsp_in_valid  = sv;
    rsp_id        = ID_W'(sid);
    rsp_last      = sl;
    rsp_out_ready = srdy;
    #3;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int id, input int tag);
    set_in(1, id, tag, 1, 0, 0, 0, 0);
    check("push_accept", 32'(req_in_ready), 32'(1));
    tick();
  endtask

  task automatic pop_expect(input int id, input int tag);
    set_in(0, 0, 0, 0, 1, id, 1, 1);
    check("pop_valid", 32'(rsp_out_valid), 32'(1));
    check("pop_tag", 32'(rsp_out_tag), 32'(tag));
    tick();
  endtask

  task automatic mid_reset();
    reset_n = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_idle", 32'(idle), 32'(1));
    for (int i = 0; i < NUM_IDS; i++) q[i].delete();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    reset_n = 1'b1;

    // Post-reset pass-through and stalls.
    set_in(1, 1, 3, 0, 1, 1, 1, 1);
    check("rst_req_out_valid", 32'(req_out_valid), 32'(1));
    check("rst_req_in_ready", 32'(req_in_ready), 32'(0));
    check("rst_rsp_out_valid", 32'(rsp_out_valid), 32'(0));
    check("rst_rsp_in_ready", 32'(rsp_in_ready), 32'(0));
    check("rst_idle", 32'(idle), 32'(1));
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Two IDs, then out-of-order across IDs; ID0 as a 4-beat burst.
    push(0, 'h11);
    push(1, 'h22);
    check("busy_two", 32'(busy), 32'('b0011));
    check("idle_two", 32'(idle), 32'(0));
    pop_expect(1, 'h22);
    for (int b = 0; b < 4; b++) begin
      set_in(0, 0, 0, 0, 1, 0, (b == 3), 1);
      check("burst_tag", 32'(rsp_out_tag), 32'('h11));
      tick();
      check("burst_busy", 32'(busy[0]), 32'(b != 3));
    end
    check("idle_after_burst", 32'(idle), 32'(1));

    // Full ID3 blocks only ID3; a same-cycle pop does not free the slot.
    push(3, 'h05);
    push(3, 'h06);
    set_in(1, 3, 'h07, 1, 0, 0, 0, 0);
    check("full_in_ready", 32'(req_in_ready), 32'(0));
    check("full_out_valid", 32'(req_out_valid), 32'(0));
    tick();
    push(2, 'h33);
    set_in(1, 3, 'h07, 1, 1, 3, 1, 1);
    check("full_pop_in_ready", 32'(req_in_ready), 32'(0));
    check("full_pop_tag", 32'(rsp_out_tag), 32'('h05));
    tick();
    push(3, 'h07);
    pop_expect(3, 'h06);
    pop_expect(3, 'h07);
    pop_expect(2, 'h33);

    // Response waiting on empty ID2 until a push arrives.
    for (int c = 0; c < 2; c++) begin
      set_in(0, 0, 0, 0, 1, 2, 1, 1);
      check("empty_stall_valid", 32'(rsp_out_valid), 32'(0));
      check("empty_stall_ready", 32'(rsp_in_ready), 32'(0));
      tick();
    end
    set_in(1, 2, 'h7F, 1, 1, 2, 1, 1);
`ifdef AXI_ID_TRACKER_FLOW_EN
    check("flow_valid", 32'(rsp_out_valid), 32'(1));
    check("flow_tag", 32'(rsp_out_tag), 32'('h7F));
    tick();
    check("flow_busy", 32'(busy[2]), 32'(0));
`else
    check("noflow_valid", 32'(rsp_out_valid), 32'(0));
    tick();
    pop_expect(2, 'h7F);
`endif
    check("idle_after_late", 32'(idle), 32'(1));

    // Full ID0 refuses push; then push+pop at count 1 across pointer wrap.
    push(0, 'h20);
    push(0, 'h21);
    set_in(1, 0, 'h30, 1, 1, 0, 1, 1);
    check("full_pushpop_ready", 32'(req_in_ready), 32'(0));
    check("full_pushpop_tag", 32'(rsp_out_tag), 32'('h20));
    tick();
    for (int k = 0; k < 3 * DEPTH; k++) begin
      set_in(1, 0, 'h40 + k, 1, 1, 0, 1, 1);
      check("wrap_ready", 32'(req_in_ready), 32'(1));
      check("wrap_tag", 32'(rsp_out_tag), (k == 0) ? 32'('h21) : 32'('h40 + k - 1));
      tick();
      check("wrap_busy", 32'(busy[0]), 32'(1));
    end
    pop_expect(0, 'h40 + 3 * DEPTH - 1);

    // Reset with tags outstanding.
    push(1, 'h12);
    push(1, 'h13);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    mid_reset();
    set_in(0, 0, 0, 0, 1, 1, 1, 1);
    check("post_reset_stall", 32'(rsp_out_valid), 32'(0));
    tick();

    // Random traffic, occasionally reset mid-stream.
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(0, 3) != 0), $urandom_range(0, NUM_IDS - 1), $urandom_range(0, 127),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, NUM_IDS - 1),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 499) == 0) begin
        mid_reset();
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_id_tag_tracker.md
# axi_id_tag_tracker

Parametrised per-ID tag tracker between an AXI4 master and slave port on one channel direction (AR→R or AW→B). Each accepted request pushes a TAG_W-bit tag into a FIFO selected by its AXI ID. The matching final response beat pops that FIFO and returns the tag alongside the response. Request and response handshakes are gated on per-ID full/empty, so in-order-per-ID tag association never over- or underflows. It generalises the team's fixed 4-ID × 7-bit tracker to configurable ID space, depth and tag width, and adds per-ID busy reporting plus optional same-cycle flow-through.

## Interface
Parameters:
- ID_W, 2, AXI ID width; NUM_IDS = 2^ID_W FIFOs
- DEPTH, 2, entries per ID FIFO; any integer ≥1
- TAG_W, 7, tag width

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_in_valid  in  1  upstream AR/AW valid
- req_in_ready  out  1  upstream AR/AW ready
- req_id  in  ID_W  request ID
- req_tag  in  TAG_W  tag to associate with request
- req_out_valid  out  1  downstream AR/AW valid
- req_out_ready  in  1  downstream AR/AW ready
- rsp_in_valid  in  1  downstream R/B valid
- rsp_in_ready  out  1  downstream R/B ready
- rsp_id  in  ID_W  response ID
- rsp_last  in  1  final beat (tie 1 for B)
- rsp_out_valid  out  1  upstream R/B valid
- rsp_out_ready  in  1  upstream R/B ready
- rsp_out_tag  out  TAG_W  head tag of FIFO[rsp_id]
- busy  out  NUM_IDS  bit i = FIFO i non-empty
- idle  out  1  all FIFOs empty

## Operation
- State per ID: DEPTH×TAG_W storage, rd/wr pointers (wrap at DEPTH-1 → 0, DEPTH need not be a power of two), count 0..DEPTH. Storage is not reset.
- full[i] = (count[i]==DEPTH); empty[i] = (count[i]==0).
- Request path: req_out_valid = req_in_valid & !full[req_id]; req_in_ready = req_out_ready & !full[req_id]. Push fires on req_in_valid & req_in_ready and writes req_tag at wr_ptr[req_id].
- Response path: rsp_out_valid = rsp_in_valid & !empty[rsp_id]; rsp_in_ready = rsp_out_ready & !empty[rsp_id]. rsp_out_tag = storage[rsp_id][rd_ptr[rsp_id]]. Non-last beats do not change state. A pop fires on rsp_in_valid & rsp_in_ready & rsp_last.
- A push and a pop on the same ID in one cycle leave count unchanged and advance both pointers. Push and pop on different IDs are independent.
- full/empty are derived from registered count only: a pop does not free a slot for a same-cycle push.
- busy and idle are derived from registered count.
- rsp_out_tag is don't-care while rsp_out_valid=0.

## Timing
- Request and response gating are combinational from registered state and current inputs; there is no added request or response latency.
- A pushed tag is visible to the response path on the cycle after the push, unless flow-through is enabled.
- After reset: all counts and pointers are 0; busy=0, idle=1, rsp_out_valid=0, rsp_in_ready=0, req_in_ready=req_out_ready, req_out_valid=req_in_valid.
- Reset asserted mid-burst: all FIFOs empty immediately (asynchronously). In-flight tags are discarded, and later responses stall until new requests arrive.

## Configuration
- AXI_ID_TRACKER_FLOW_EN defined: if FIFO[rsp_id] is empty and a push to the same ID fires in the same cycle, then rsp_out_valid=rsp_in_valid, rsp_in_ready=rsp_out_ready, and rsp_out_tag=req_tag.
  - If that response beat also pops (last), count stays 0 and the pointers do not move.
  - If it is a non-last beat, the push is stored normally.
  - This creates a combinational path req→rsp.
- Undefined: no flow-through. A response on an empty ID always stalls, and there is no req→rsp combinational path.

## Test plan
- Reset, then push IDs 0,1 with tags 0x11,0x22 → busy=0b0011, idle=0. Responses with last on ID1 then ID0 return tags 0x22 then 0x11 → idle=1.
- DEPTH=2: push ID3 tags 0x05,0x06. A third push on ID3 → req_in_ready=0 and req_out_valid=0, while a push on ID2 still passes. Then pop ID3 → returns 0x05; next cycle the third push is accepted.
- R burst of 4 beats on ID0 with rsp_last only on beat 4 → all 4 beats carry the same tag 0x11, and count decrements only after beat 4.
- Response on empty ID2 → rsp_out_valid=0 and rsp_in_ready=0, held stalled until a push to ID2 (tag 0x7F). The response completes next cycle with tag 0x7F (FLOW_EN undefined). With FLOW_EN defined, it completes in the push cycle with count staying 0.
- Full ID0 with simultaneous push and pop → push refused. With count 1, simultaneous push+pop → count stays 1 and FIFO order is preserved across pointer wrap over 3×DEPTH operations.
- Assert reset_n=0 with 2 tags outstanding → busy=0 and idle=1 immediately. A following response on that ID stalls.
